mult_sequencer: RTL

Hardware sequencer for program 3, double-precision two's-complement multiplication.
- Walks 16 operand pairs in data memory and forms each signed 16x16 product with an iterative 16-step multiply.
- Writes each 32-bit product back to data memory, then raises done.
- Sits beside the data memory in top_level as the done-producing master, with the same memory image, reset-as-start and done semantics as the core flow.

---
 rtl/mult_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mult_sequencer
// Purpose  : Walks NUM_PAIRS signed 16-bit operand pairs in data memory, forms
//            each 32-bit product with a 16-step radix-2 Booth multiply and
//            writes it back big-endian; raises done when finished.
// Option   : MULT_SEQ_CYCLE_CNT_EN adds a 16-bit cycle_count output.
// Revision : 1.0
// ============================================================================
module mult_sequencer #(
    parameter int NUM_PAIRS = 16,
    parameter int SRC_BASE  = 0,
    parameter int DST_BASE  = 64,
    parameter int AW        = 8,
    parameter int DW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rd_data,
    output logic          mem_wr_en,
    output logic [DW-1:0] mem_wr_data,
    output logic          done
`ifdef MULT_SEQ_CYCLE_CNT_EN
    ,
    output logic [15:0]   cycle_count
`endif
);

    localparam int c_PW = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
    localparam logic [c_PW-1:0] c_LAST_PAIR = c_PW'(NUM_PAIRS - 1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_MUL   = 2'd1,
        S_STORE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    logic [c_PW-1:0] r_pair;
    logic [1:0]      r_byte_idx;
    logic [3:0]      r_step;
    logic [15:0]     r_a;
    logic [7:0]      r_b_hi;
    logic [32:0]     r_acc;
    logic            r_qm1;

    logic [16:0]     w_m_ext;
    logic [16:0]     w_hi_sum;
    logic [32:0]     w_acc_next;

    function automatic logic [AW-1:0] f_src(input logic [c_PW-1:0] p, input logic [1:0] k);
        return AW'(SRC_BASE + 4 * int'(p) + int'(k));
    endfunction

    function automatic logic [AW-1:0] f_dst(input logic [c_PW-1:0] p, input logic [1:0] k);
        return AW'(DST_BASE + 4 * int'(p) + int'(k));
    endfunction

    function automatic logic [7:0] f_prod_byte(input logic [31:0] p, input logic [1:0] k);
        case (k)
            2'd0:    return p[31:24];
            2'd1:    return p[23:16];
            2'd2:    return p[15:8];
            default: return p[7:0];
        endcase
    endfunction

    // Booth step: upper part is 17 bits so that -(-32768) cannot overflow.
    always_comb begin
        w_m_ext = {r_a[15], r_a};
        case ({r_acc[0], r_qm1})
            2'b01:   w_hi_sum = r_acc[32:16] + w_m_ext;
            2'b10:   w_hi_sum = r_acc[32:16] - w_m_ext;
            default: w_hi_sum = r_acc[32:16];
        endcase
        w_acc_next = {w_hi_sum[16], w_hi_sum, r_acc[15:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_LOAD;
            r_pair      <= '0;
            r_byte_idx  <= '0;
            r_step      <= '0;
            r_a         <= '0;
            r_b_hi      <= '0;
            r_acc       <= '0;
            r_qm1       <= 1'b0;
            done        <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= '0;
            mem_addr    <= AW'(SRC_BASE);
        end else begin
            case (r_state)
                S_LOAD: begin
                    case (r_byte_idx)
                        2'd0: r_a[15:8] <= mem_rd_data[7:0];
                        2'd1: r_a[7:0]  <= mem_rd_data[7:0];
                        2'd2: r_b_hi    <= mem_rd_data[7:0];
                        default: begin
                            r_acc   <= {17'd0, r_b_hi, mem_rd_data[7:0]};
                            r_qm1   <= 1'b0;
                            r_step  <= '0;
                            r_state <= S_MUL;
                        end
                    endcase
                    r_byte_idx <= r_byte_idx + 2'd1;
                    if (r_byte_idx != 2'd3) begin
                        mem_addr <= f_src(r_pair, r_byte_idx + 2'd1);
                    end
                end
                S_MUL: begin
                    r_acc  <= w_acc_next;
                    r_qm1  <= r_acc[0];
                    r_step <= r_step + 4'd1;
                    // The last step's result is presented directly as the first store byte.
                    if (r_step == 4'd15) begin
                        r_state     <= S_STORE;
                        r_byte_idx  <= '0;
                        mem_wr_en   <= 1'b1;
                        mem_addr    <= f_dst(r_pair, 2'd0);
                        mem_wr_data <= DW'(w_acc_next[31:24]);
                    end
                end
                S_STORE: begin
                    if (r_byte_idx == 2'd3) begin
                        mem_wr_en   <= 1'b0;
                        mem_wr_data <= '0;
                        if (r_pair == c_LAST_PAIR) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_pair     <= r_pair + c_PW'(1);
                            r_byte_idx <= '0;
                            mem_addr   <= f_src(r_pair + c_PW'(1), 2'd0);
                            r_state    <= S_LOAD;
                        end
                    end else begin
                        r_byte_idx  <= r_byte_idx + 2'd1;
                        mem_addr    <= f_dst(r_pair, r_byte_idx + 2'd1);
                        mem_wr_data <= DW'(f_prod_byte(r_acc[31:0], r_byte_idx + 2'd1));
                    end
                end
                default: begin
                    done      <= 1'b1;
                    mem_wr_en <= 1'b0;
                end
            endcase
        end
    end

`ifdef MULT_SEQ_CYCLE_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count <= '0;
        end else if (!done) begin
            cycle_count <= cycle_count + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire
